// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - shared widths, fetch state encoding and long-opcode decode for the fetch stage
package nibbler_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam logic [3:0] LONG_OP_MIN = 4'hA;

    typedef enum logic {
        ST_OP  = 1'b0,
        ST_ARG = 1'b1
    } fetch_state_t;

    function automatic logic is_long_op(input logic [3:0] opc);
        return opc >= LONG_OP_MIN;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC and instruction fetch stage for one- and two-byte instructions
// Optional macro FETCH_HALT_EN adds a halt input that freezes all fetch state.
module fetch_sequencer
    import nibbler_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              phase,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              jump_take,
`ifdef FETCH_HALT_EN
    input  logic              halt,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] operand,
    output logic              exec_en
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] opr_q, opr_d;
    fetch_state_t      state_q, state_d;
    logic              ready_q, ready_d;
    logic              hold;

`ifdef FETCH_HALT_EN
    assign hold = halt;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            opr_q   <= '0;
            state_q <= ST_OP;
            ready_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            opr_q   <= opr_d;
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        opr_d   = opr_q;
        state_d = state_q;
        ready_d = ready_q;
        if (!hold) begin
            if (!phase) begin
                // Fetch slot: a long opcode waits one more fetch slot for its operand byte
                if (state_q == ST_OP) begin
                    ir_d = rom_data;
                    if (is_long_op(rom_data[7:4])) begin
                        ready_d = 1'b0;
                        state_d = ST_ARG;
                    end else begin
                        ready_d = 1'b1;
                    end
                end else begin
                    opr_d   = rom_data;
                    ready_d = 1'b1;
                    state_d = ST_OP;
                end
            end else begin
                if (ready_q && is_long_op(ir_q[7:4]) && jump_take) begin
                    pc_d = {ir_q[3:0], opr_q};
                end else begin
                    pc_d = pc_q + 1'b1;
                end
                ready_d = 1'b0;
            end
        end
    end

    assign rom_addr = pc_q;
    assign instr    = ir_q;
    assign operand  = opr_q;
    assign exec_en  = phase & ready_q & ~hold;

endmodule
